// File: rtl/mastermind_scoreboard.sv
// Mastermind scoreboard: logs each scored round into a history buffer and tracks
// the round count and the game outcome. It also provides a registered read port for display.
module mastermind_scoreboard #(
  parameter int MAX_GUESSES = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             result_valid,
  input  logic [2:0]       red_in,
  input  logic [2:0]       white_in,
  input  logic [11:0]      guess_in,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [11:0]      rd_guess,
  output logic [2:0]       rd_red,
  output logic [2:0]       rd_white,
  output logic [3:0]       guess_count,
  output logic [1:0]       game_state,
  output logic             win,
  output logic             lose,
  output logic             fb_error
);

  localparam int         DEPTH   = 1 << IDX_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_GUESSES);

  typedef enum logic [1:0] {
    ST_PLAYING = 2'b00,
    ST_WON     = 2'b01,
    ST_LOST    = 2'b10
  } state_t;

  state_t      state_r, next_state_s;
  logic [3:0]  count_r, count_inc_s;
  logic        store_s, err_s, fb_error_r;
  logic        win_r, lose_r;
  logic [17:0] hist_r [DEPTH];
  logic        rd_valid_r;
  logic [17:0] rd_data_r;
  logic        rd_hit_s;

  // Feedback is illegal if either count exceeds 4 or their sum does (at 4-bit width).
  function automatic logic fb_illegal(input logic [2:0] red, input logic [2:0] white);
    logic [3:0] sum;
    sum = {1'b0, red} + {1'b0, white};
    return (red > 3'd4) || (white > 3'd4) || (sum > 4'd4);
  endfunction

  // Next-state, round-accept and error decode.
  always_comb begin
    next_state_s = state_r;
    store_s      = 1'b0;
    err_s        = 1'b0;
    count_inc_s  = count_r + 4'd1;
    if (new_game) begin
      next_state_s = ST_PLAYING;
    end else begin
      case (state_r)
        ST_PLAYING: begin
          if (result_valid) begin
            if (fb_illegal(red_in, white_in)) begin
              err_s = 1'b1;
            end else begin
              store_s = 1'b1;
              // A win on the final round beats running out of guesses.
              if (red_in == 3'd4) begin
                next_state_s = ST_WON;
              end else if (count_inc_s == MAX_CNT) begin
                next_state_s = ST_LOST;
              end else begin
                next_state_s = ST_PLAYING;
              end
            end
          end else begin
            next_state_s = ST_PLAYING;
          end
        end
        ST_WON:  next_state_s = ST_WON;
        ST_LOST: next_state_s = ST_LOST;
        default: next_state_s = ST_PLAYING;
      endcase
    end
  end

  // Outcome state register with win/lose flags aligned to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_PLAYING;
      win_r   <= 1'b0;
      lose_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      win_r   <= (next_state_s == ST_WON);
      lose_r  <= (next_state_s == ST_LOST);
    end
  end

  // History buffer, round counter and sticky feedback-error flag.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      count_r    <= 4'd0;
      fb_error_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= 18'd0;
      end
    end else begin
      if (store_s) begin
        hist_r[count_r[IDX_W-1:0]] <= {guess_in, red_in, white_in};
        count_r                    <= count_inc_s;
      end
      if (err_s) begin
        fb_error_r <= 1'b1;
      end
    end
  end

  assign rd_hit_s = (4'(rd_idx) < count_r);

  // Read port: one-cycle latency, zeros for entries not yet logged this game.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 18'd0;
    end else if (rd_en) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= rd_hit_s ? hist_r[rd_idx] : 18'd0;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_valid    = rd_valid_r;
  assign rd_guess    = rd_data_r[17:6];
  assign rd_red      = rd_data_r[5:3];
  assign rd_white    = rd_data_r[2:0];
  assign guess_count = count_r;
  assign game_state  = state_r;
  assign win         = win_r;
  assign lose        = lose_r;
  assign fb_error    = fb_error_r;

endmodule

// File: doc/mastermind_scoreboard.md
Name: mastermind_scoreboard

Overview:
- Downstream of the datapath/compare stage; consumes the per-round red/white feedback and the submitted guess.
- Logs each round into a guess history buffer, counts rounds and runs the game-outcome FSM (PLAYING / WON / LOST).
- Provides a registered history read port for the display logic, plus win/lose flags and the round count.

Parameters:
- MAX_GUESSES, 8, rounds allowed per game; legal range 1..15.
- IDX_W, 3, history index width; 2**IDX_W >= MAX_GUESSES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  single-cycle pulse; clears history and returns the FSM to PLAYING.
- result_valid  in  1  single-cycle pulse; red_in, white_in and guess_in are final this cycle.
- red_in  in  3  red peg count, 0..4.
- white_in  in  3  white peg count, 0..4.
- guess_in  in  12  submitted guess, four 3-bit symbols, symbol 1 in [2:0].
- rd_en  in  1  history read request.
- rd_idx  in  IDX_W  history entry to read; 0 is the oldest.
- rd_valid  out  1  rd_guess/rd_red/rd_white hold requested data.
- rd_guess  out  12  stored guess.
- rd_red  out  3  stored red count.
- rd_white  out  3  stored white count.
- guess_count  out  4  rounds logged this game.
- game_state  out  2  00 PLAYING, 01 WON, 10 LOST.
- win  out  1  high while game_state is WON.
- lose  out  1  high while game_state is LOST.
- fb_error  out  1  sticky; an illegal feedback was received this game.

Behaviour:
- Reset values:
  - guess_count = 0, game_state = PLAYING, win = lose = fb_error = 0.
  - rd_valid = 0; rd_guess, rd_red, rd_white = 0.
  - All history entries cleared to 0.
- Accepting a round: result_valid is accepted only in PLAYING.
  - On the accepting edge, history[guess_count] <= {guess_in, red_in, white_in} and guess_count increments.
  - The new entry is readable from the next cycle.
- Illegal feedback: red_in > 4, white_in > 4, or red_in + white_in > 4 (computed at 4-bit width).
  - The round is not stored, guess_count is unchanged, fb_error <= 1, and the state stays PLAYING.
- FSM transitions, decided on the same edge the round is logged:
  - PLAYING -> WON when a legal round has red_in == 4.
  - PLAYING -> LOST when a legal round has red_in != 4 and the incremented guess_count == MAX_GUESSES.
  - Win on the final round means WON; WON takes priority over LOST.
  - WON and LOST are absorbing. result_valid is ignored in these states: nothing stored, no count change, no error.
- new_game: next cycle guess_count = 0, game_state = PLAYING, fb_error = 0, all entries = 0.
  - new_game and result_valid in the same cycle: new_game wins and the round is discarded.
- win and lose are registered and change on the same edge as game_state.
- Read port, 1-cycle latency:
  - rd_en at edge N gives rd_valid = 1 and the data from edge N+1, held until the next rd_en.
  - rd_idx >= guess_count returns zeros with rd_valid = 1.
  - Reading the entry written on the same edge returns the old (pre-write) contents.
  - rd_valid drops to 0 the cycle after any cycle without rd_en.
- reset or new_game while a read is in flight: rd_valid <= 0 and the outputs go to 0; reset or new_game beats rd_en.
- Width rules: guess_count saturates at MAX_GUESSES; it is never incremented past it because the state is LOST or WON by then.

Test Plan:
- Reset, then 3 legal rounds (red/white 1/2, 0/0, 2/1) -> guess_count = 3, PLAYING; reading idx 1 gives rd_red = 0, rd_white = 0, rd_guess matches the 2nd guess, one cycle after rd_en.
- Round with red = 4, white = 0 on round 2 -> WON, win = 1; a later result_valid with red = 1 leaves guess_count = 2 and the state WON.
- 8 rounds, none with red = 4 -> LOST on the 8th accept, lose = 1, guess_count = 8; a 9th result_valid is ignored.
- Round 8 with red = 4 -> WON, not LOST.
- red = 3, white = 2 -> fb_error = 1, guess_count unchanged; a following legal round is logged at idx 0; new_game clears fb_error.
- new_game and result_valid in the same cycle after 5 rounds -> guess_count = 0, PLAYING; idx 0 reads zeros. A reset asserted mid-read -> rd_valid = 0 on the next cycle.
